// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - frame-level scheduler for one convolutional layer instance
//
// Accepts a raster-order pixel stream, pulses conv_clk_en once per accepted
// pixel, tracks row/column/frame position, qualifies layer output for full
// filter windows and stalls the layer under downstream backpressure.
// Optional statistics outputs are enabled by defining CONV_SEQ_STATS_EN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, frames       job request and frame count (sampled in IDLE)
//   in_valid, in_ready  upstream pixel handshake
//   conv_clk_en         layer advance enable (in_valid & in_ready)
//   out_ready           downstream accepts window result
//   out_valid           window result valid
//   out_row, out_col    window top-left coordinates
//   out_last            last window of the current frame
//   busy, done          job in progress / one-cycle job-end pulse
//   stall_cycles        (CONV_SEQ_STATS_EN) backpressure cycle count, saturating
//   frames_done         (CONV_SEQ_STATS_EN) frames whose last window was handed off

`timescale 1ns/1ps

module conv_layer_sequencer #(
   parameter int IMAGE_SIZE      = 28,
   parameter int FILTER_SIZE     = 5,
   parameter int FRAME_CNT_WIDTH = 16,
   localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [FRAME_CNT_WIDTH-1:0] frames,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       conv_clk_en,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [CW-1:0]              out_row,
   output logic [CW-1:0]              out_col,
   output logic                       out_last,
   output logic                       busy,
`ifdef CONV_SEQ_STATS_EN
   output logic [31:0]                stall_cycles,
   output logic [FRAME_CNT_WIDTH-1:0] frames_done,
`endif
   output logic                       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_SIZE - 1);
   localparam logic [CW-1:0] F_M1     = CW'(FILTER_SIZE - 1);

   state_t                     state;
   logic [CW-1:0]              row;
   logic [CW-1:0]              col;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
   logic [FRAME_CNT_WIDTH-1:0] frames_reg;

   logic accept;
   logic last_pix;
   logic last_frame;
   logic qualify;
   logic handoff;

   // A held result may only be replaced in the same cycle it is handed off.
   assign in_ready    = (state == STREAM) & (~out_valid | out_ready);
   assign accept      = in_valid & in_ready;
   assign conv_clk_en = accept;

   assign last_pix   = (row == LAST_IDX) & (col == LAST_IDX);
   // frame_cnt counts completed frames, so the final frame is frames_reg-1.
   assign last_frame = (frame_cnt == (frames_reg - FRAME_CNT_WIDTH'(1)));
   // Window is complete once the pixel at its bottom-right corner arrives.
   assign qualify    = accept & (row >= F_M1) & (col >= F_M1);
   assign handoff    = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         row          <= '0;
         col          <= '0;
         frame_cnt    <= '0;
         frames_reg   <= '0;
         out_valid    <= 1'b0;
         out_row      <= '0;
         out_col      <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef CONV_SEQ_STATS_EN
         stall_cycles <= '0;
         frames_done  <= '0;
`endif
      end else begin
         // Raster position advance.
         if (accept) begin
            if (col == LAST_IDX) begin
               col <= '0;
               if (row == LAST_IDX) begin
                  row       <= '0;
                  frame_cnt <= frame_cnt + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end

         // Result register: a new window takes priority over clearing on handoff.
         if (qualify) begin
            out_valid <= 1'b1;
            out_row   <= row - F_M1;
            out_col   <= col - F_M1;
            out_last  <= last_pix;
         end else if (handoff) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

`ifdef CONV_SEQ_STATS_EN
         if ((state == STREAM || state == DRAIN) && out_valid && !out_ready &&
             stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
         if (handoff && out_last)
            frames_done <= frames_done + 1'b1;
`endif

         case (state)
            IDLE: begin
               if (start) begin
                  row        <= '0;
                  col        <= '0;
                  frame_cnt  <= '0;
                  frames_reg <= frames;
                  busy       <= 1'b1;
`ifdef CONV_SEQ_STATS_EN
                  stall_cycles <= '0;
                  frames_done  <= '0;
`endif
                  if (frames == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (accept && last_pix && last_frame)
                  state <= DRAIN;
            end
            DRAIN: begin
               // Hold off completion until the final window has been taken.
               if (!out_valid || out_ready) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - self-checking bench for conv_layer_sequencer

`timescale 1ns/1ps

module tb_conv_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] frames;
   logic        in_valid;
   logic        in_ready;
   logic        conv_clk_en;
   logic        out_ready;
   logic        out_valid;
   logic [1:0]  out_row;
   logic [1:0]  out_col;
   logic        out_last;
   logic        busy;
   logic        done;
`ifdef CONV_SEQ_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] frames_done;
`endif

   always #5 clk = ~clk;

   conv_layer_sequencer #(
      .IMAGE_SIZE(4),
      .FILTER_SIZE(3),
      .FRAME_CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .frames(frames),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .conv_clk_en(conv_clk_en),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_row(out_row),
      .out_col(out_col),
      .out_last(out_last),
      .busy(busy),
`ifdef CONV_SEQ_STATS_EN
      .stall_cycles(stall_cycles),
      .frames_done(frames_done),
`endif
      .done(done)
   );

   typedef struct {
      logic        start;
      logic [15:0] frames;
      logic        in_valid;
      logic        out_ready;
      logic        e_ir;
      logic        e_en;
      logic        e_ov;
      logic [1:0]  e_row;
      logic [1:0]  e_col;
      logic        e_last;
      logic        e_busy;
      logic        e_done;
   } vec_t;

   vec_t tbl [20];

   int n_cmp = 0;
   int n_bad = 0;

   int pix, nir, ndone, done_cyc;
   int win_r[$];
   int win_c[$];
   int win_l[$];
   int win_p[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Runs one job with in_valid held high; optionally holds out_ready low for
   // stall_len cycles starting when the first window appears.
   task automatic run_job(input logic [15:0] nf, input int stall_len);
      int  stall_left;
      bit  stalled;
      bit  fin;
      pix = 0; nir = 0; ndone = 0; done_cyc = -1;
      win_r.delete(); win_c.delete(); win_l.delete(); win_p.delete();
      stall_left = 0; stalled = 0; fin = 0;
      @(negedge clk); start = 1'b1; frames = nf; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         if (!stalled && stall_len > 0 && out_valid) begin
            stalled    = 1;
            stall_left = stall_len;
         end
         out_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_clk_en", conv_clk_en, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_row", out_row, 0);
            chk("stall_out_col", out_col, 0);
            stall_left--;
         end
         if (in_ready) nir++;
         if (out_valid && out_ready) begin
            win_r.push_back(out_row);
            win_c.push_back(out_col);
            win_l.push_back(out_last);
            win_p.push_back(pix - 1);
         end
         if (conv_clk_en) pix++;
         if (done) begin
            ndone++;
            done_cyc = cyc;
            fin = 1;
         end
         @(negedge clk);
      end
      if (!fin) chk("job_timeout", 0, 1);
      #1;
      chk("busy_after_done", busy, 0);
      chk("done_single_pulse", done, 0);
   endtask

   task automatic check_windows(input int nfr);
      int nlast;
      nlast = 0;
      chk("window_count", win_r.size(), 4 * nfr);
      for (int k = 0; k < win_r.size() && k < 4 * nfr; k++) begin
         chk($sformatf("win%0d_row", k), win_r[k], (k % 4) / 2);
         chk($sformatf("win%0d_col", k), win_c[k], k % 2);
         chk($sformatf("win%0d_last", k), win_l[k], (k % 4 == 3) ? 1 : 0);
         nlast += win_l[k];
      end
      chk("out_last_count", nlast, nfr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Scenario 1 cycle table: cycle 0 is the start cycle, pixel p is accepted
      // in cycle p+1 and its window appears in cycle p+2.
      for (int i = 0; i < 20; i++)
         tbl[i] = '{1'b0, 16'd0, 1'b1, 1'b1,
                    (i >= 1 && i <= 16), (i >= 1 && i <= 16),
                    1'b0, 2'd0, 2'd0, 1'b0,
                    (i >= 1 && i <= 18), (i == 18)};
      tbl[0].start  = 1'b1;
      tbl[0].frames = 16'd1;
      tbl[12].e_ov = 1'b1; tbl[12].e_row = 2'd0; tbl[12].e_col = 2'd0;
      tbl[13].e_ov = 1'b1; tbl[13].e_row = 2'd0; tbl[13].e_col = 2'd1;
      tbl[16].e_ov = 1'b1; tbl[16].e_row = 2'd1; tbl[16].e_col = 2'd0;
      tbl[17].e_ov = 1'b1; tbl[17].e_row = 2'd1; tbl[17].e_col = 2'd1; tbl[17].e_last = 1'b1;

      rst_n = 1'b0; start = 1'b0; frames = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rowcol", {out_row, out_col}, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = tbl[i].start; frames = tbl[i].frames;
         in_valid = tbl[i].in_valid; out_ready = tbl[i].out_ready;
         #1;
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("v%0d_clk_en", i), conv_clk_en, tbl[i].e_en);
         chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
         if (tbl[i].e_ov) begin
            chk($sformatf("v%0d_out_row", i), out_row, tbl[i].e_row);
            chk($sformatf("v%0d_out_col", i), out_col, tbl[i].e_col);
         end
         chk($sformatf("v%0d_out_last", i), out_last, tbl[i].e_last);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
      end

      // Scenario 2: 5-cycle downstream stall on the first window.
      run_job(16'd1, 5);
      chk("s2_pixels", pix, 16);
      chk("s2_done_count", ndone, 1);
      check_windows(1);
`ifdef CONV_SEQ_STATS_EN
      chk("s2_stall_cycles", stall_cycles, 5);
      chk("s2_frames_done", frames_done, 1);
`endif

      // Scenario 3: three back-to-back frames.
      run_job(16'd3, 0);
      chk("s3_pixels", pix, 48);
      chk("s3_done_count", ndone, 1);
      check_windows(3);
      if (win_p.size() >= 5) begin
         chk("s3_first_win_pix", win_p[0], 10);
         chk("s3_frame2_first_win_pix", win_p[4], 26);
      end else begin
         chk("s3_win_pix_available", win_p.size(), 5);
      end

      // Scenario 4: zero-frame job.
      run_job(16'd0, 0);
      chk("s4_pixels", pix, 0);
      chk("s4_in_ready_cycles", nir, 0);
      chk("s4_done_cycle", done_cyc, 0);
      chk("s4_windows", win_r.size(), 0);

      // Scenario 5: reset right after pixel 7 of the frame is accepted.
      @(negedge clk); start = 1'b1; frames = 16'd1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_clk_en", conv_clk_en, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_rowcol", {out_row, out_col}, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
`ifdef CONV_SEQ_STATS_EN
      chk("mid_rst_stall_cycles", stall_cycles, 0);
      chk("mid_rst_frames_done", frames_done, 0);
`endif
      @(negedge clk); rst_n = 1'b1;
      run_job(16'd1, 0);
      chk("s5_pixels", pix, 16);
      check_windows(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Frame-level scheduler for one convolutional layer instance.
- Accepts a raster-order pixel stream from upstream over a valid/ready handshake and issues one clk_en pulse to the layer per accepted pixel.
- Tracks row/column position, qualifies the layer output only for full filter windows, and applies downstream backpressure by stalling the layer.
- Runs a programmed number of frames per start command, then signals done.

Parameters:
IMAGE_SIZE  28  square input image side, pixels
FILTER_SIZE  5  square filter side; 1 <= FILTER_SIZE <= IMAGE_SIZE
FRAME_CNT_WIDTH  16  width of frame-count operand

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
frames  in  FRAME_CNT_WIDTH  frames in the job; sampled with start
in_valid  in  1  upstream pixel present
in_ready  out  1  sequencer accepts pixel this cycle
conv_clk_en  out  1  advance enable to the layer (combinational, = in_valid & in_ready)
out_ready  in  1  downstream accepts window result
out_valid  out  1  layer output_data holds a valid window result
out_row  out  CW  window top-left row; CW = `LOG2(IMAGE_SIZE)
out_col  out  CW  window top-left column
out_last  out  1  qualifies last window of current frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async assert, sync deassert): state IDLE; row, col, frame counters 0.
  - in_ready, out_valid, out_last, busy, done = 0; out_row, out_col = 0.
- The clock and reset are the only ones; clk_en semantics follow the layer, one pulse per pixel.
- States:
  - IDLE -> STREAM on start with frames != 0.
  - IDLE -> DONE on start with frames == 0.
  - STREAM -> DRAIN on acceptance of the last pixel of the last frame.
  - DRAIN -> DONE when out_valid is 0, or out_valid & out_ready.
  - DONE -> IDLE unconditionally; done = 1 only in DONE.
- start outside IDLE is ignored.
- in_ready = (state == STREAM) & (!out_valid | out_ready). A held result is never overwritten.
- Acceptance (in_valid & in_ready):
  - col increments; on wrap to 0 at IMAGE_SIZE-1, row increments.
  - At row = col = IMAGE_SIZE-1, both wrap to 0 and the frame counter increments.
- Window qualification on acceptance of pixel (row, col), evaluated with pre-increment values:
  - Condition: row >= FILTER_SIZE-1 and col >= FILTER_SIZE-1.
  - On the next edge: out_valid = 1, out_row = row-FILTER_SIZE+1, out_col = col-FILTER_SIZE+1.
  - out_last = (row == IMAGE_SIZE-1 & col == IMAGE_SIZE-1).
- Latency: result visible one cycle after the accepting edge, matching the layer's registered pixel buffer.
- out_valid clears on out_valid & out_ready unless a new qualifying pixel is accepted in the same cycle; in that case it stays 1 with the new coordinates.
- Windows per frame: (IMAGE_SIZE-FILTER_SIZE+1)^2; exactly one out_last per frame.
- Frame boundaries: there are no idle cycles between frames. The first FILTER_SIZE-1 rows of each frame produce no out_valid.
- in_valid low: no clk_en, counters hold, layer frozen.
- Reset mid-frame: all state is discarded and the partial frame is lost. Upstream must restart the frame from pixel (0,0).
- FILTER_SIZE == IMAGE_SIZE: one window per frame, at the last pixel.

Optional Feature:
CONV_SEQ_STATS_EN
- Defined: adds outputs stall_cycles [31:0] and frames_done [FRAME_CNT_WIDTH-1:0].
  - Both clear on reset and on start accepted in IDLE.
  - stall_cycles increments on every STREAM/DRAIN cycle with out_valid & !out_ready; it saturates at all-ones.
  - frames_done increments on each out_last handshake.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- IMAGE_SIZE=4, FILTER_SIZE=3, frames=1, in_valid=1, out_ready=1 -> 16 conv_clk_en pulses.
  - out_valid one cycle after pixel indices 10, 11, 14, 15, coordinates (0,0), (0,1), (1,0), (1,1).
  - out_last only with (1,1); done pulses 2 cycles after the last pixel; busy low after.
- Same config, out_ready held 0 from the first valid window for 5 cycles -> in_ready = 0 and no conv_clk_en during the stall.
  - out_row/out_col hold (0,0); resumes with no lost or duplicated window.
- frames=3, continuous stream -> 48 pixels accepted, 12 windows, 3 out_last pulses, a single done.
  - Frame-2 first window at overall pixel index 26.
- start with frames=0 -> DONE next cycle, done pulse, no in_ready.
- rst_n asserted after pixel 7 of frame 1 -> all outputs 0 immediately.
  - After release plus start with frames=1, the full 4-window sequence repeats from (0,0).
- With CONV_SEQ_STATS_EN, second scenario -> stall_cycles = 5, frames_done = 1 at done.
